// File: rtl/cam_capture_rgb332_pkg.sv
// Shared definitions for the OV7670 capture path: default geometry, FSM encoding and the
// RGB565 -> RGB332 bit-slice positions (also consumed by the display side).
package cam_capture_rgb332_pkg;

    localparam int unsigned CAM_DEF_AW       = 17;
    localparam int unsigned CAM_DEF_DW       = 8;
    localparam int unsigned CAM_DEF_SCREEN_X = 320;
    localparam int unsigned CAM_DEF_SCREEN_Y = 240;

    typedef enum logic [1:0] {
        S_WAIT_VS_HI = 2'd0,
        S_WAIT_VS_LO = 2'd1,
        S_FRAME      = 2'd2,
        S_LINE       = 2'd3
    } cam_state_e;

    // byte1 = R4..R0 G5..G3, byte2 = G2..G0 B4..B0; RGB332 keeps the top bits of each channel
    localparam int unsigned RGB_R_HI = 7;
    localparam int unsigned RGB_R_LO = 5;
    localparam int unsigned RGB_G_HI = 2;
    localparam int unsigned RGB_G_LO = 0;
    localparam int unsigned RGB_B_HI = 4;
    localparam int unsigned RGB_B_LO = 3;

endpackage

// File: rtl/cam_capture_rgb332_if.sv
// Write port of the dual-port frame buffer: one-cycle strobe with address and RGB332 pixel.
interface cam_capture_rgb332_if #(
    parameter int unsigned AW = 17,
    parameter int unsigned DW = 8
) ();

    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic          ram_we;

    modport master (
        output ram_addr,
        output ram_data,
        output ram_we
    );

    modport slave (
        input ram_addr,
        input ram_data,
        input ram_we
    );

endinterface

// File: rtl/cam_sync_edge.sv
// Three-flop synchroniser for one asynchronous camera line; level and edge pulses come from
// the second and third stages so they stay aligned with a two-flop data path.
module cam_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_level = r_s2;
    assign o_rise  = r_s2 & ~r_s3;
    assign o_fall  = ~r_s2 & r_s3;

endmodule

// File: rtl/cam_capture_rgb332.sv
// OV7670 capture: oversamples the camera bus in clk, pairs RGB565 bytes, converts to RGB332
// and writes the cropped frame into the frame buffer write port.
module cam_capture_rgb332
    import cam_capture_rgb332_pkg::*;
#(
    parameter int unsigned AW           = CAM_DEF_AW,
    parameter int unsigned DW           = CAM_DEF_DW,
    parameter int unsigned CAM_SCREEN_X = CAM_DEF_SCREEN_X,
    parameter int unsigned CAM_SCREEN_Y = CAM_DEF_SCREEN_Y
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cam_pclk,
    input  logic                  i_cam_href,
    input  logic                  i_cam_vsync,
    input  logic [7:0]            i_cam_data,
    cam_capture_rgb332_if.master  o_ram,
    output logic                  o_frame_done,
    output logic                  o_frame_err,
    output logic                  o_busy
);

    localparam int unsigned CW = $clog2(CAM_SCREEN_X + 1);
    localparam int unsigned RW = $clog2(CAM_SCREEN_Y + 1);
    localparam logic [CW-1:0] COL_MAX = CW'(CAM_SCREEN_X);
    localparam logic [RW-1:0] ROW_MAX = RW'(CAM_SCREEN_Y);

    logic       w_pclk_level, w_pclk_rise, w_pclk_fall;
    logic       w_href, w_href_rise, w_href_fall;
    logic       w_vs, w_vs_rise, w_vs_fall;
    logic [7:0] r_data_s1, r_data_s2;

    cam_sync_edge u_sync_pclk (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_cam_pclk),
        .o_level (w_pclk_level),
        .o_rise  (w_pclk_rise),
        .o_fall  (w_pclk_fall)
    );

    cam_sync_edge u_sync_href (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_cam_href),
        .o_level (w_href),
        .o_rise  (w_href_rise),
        .o_fall  (w_href_fall)
    );

    cam_sync_edge u_sync_vsync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_cam_vsync),
        .o_level (w_vs),
        .o_rise  (w_vs_rise),
        .o_fall  (w_vs_fall)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data_s1 <= '0;
            r_data_s2 <= '0;
        end else begin
            r_data_s1 <= i_cam_data;
            r_data_s2 <= r_data_s1;
        end
    end

    cam_state_e r_state, w_state_nxt;
    logic       w_start_frame, w_end_frame, w_in_line;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_WAIT_VS_HI;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_WAIT_VS_HI: if (w_vs) w_state_nxt = S_WAIT_VS_LO;
            S_WAIT_VS_LO: if (!w_vs) w_state_nxt = S_FRAME;
            S_FRAME: begin
                if (w_vs)             w_state_nxt = S_WAIT_VS_LO;
                else if (w_href_rise) w_state_nxt = S_LINE;
            end
            S_LINE: begin
                if (w_vs)             w_state_nxt = S_WAIT_VS_LO;
                else if (w_href_fall) w_state_nxt = S_FRAME;
            end
            default: w_state_nxt = S_WAIT_VS_HI;
        endcase
    end

    always_comb begin
        w_start_frame = (r_state == S_WAIT_VS_LO) && !w_vs;
        w_end_frame   = ((r_state == S_FRAME) || (r_state == S_LINE)) && w_vs;
        w_in_line     = (r_state == S_LINE) && !w_vs;
    end

    logic [CW-1:0] r_col, w_col_nxt;
    logic [RW-1:0] r_row, w_row_nxt;
    logic [AW-1:0] r_row_base, w_row_base_nxt;
    logic          r_phase, w_phase_nxt;
    logic [7:0]    r_byte1, w_byte1_nxt;
    logic          r_we, w_we_nxt;
    logic [AW-1:0] r_addr, w_addr_nxt;
    logic [DW-1:0] r_data, w_data_nxt;
    logic          r_err, w_err_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_done, w_done_nxt;
    logic [DW-1:0] w_pix;

    assign w_pix = {r_byte1[RGB_R_HI:RGB_R_LO], r_byte1[RGB_G_HI:RGB_G_LO],
                    r_data_s2[RGB_B_HI:RGB_B_LO]};

    always_comb begin
        w_col_nxt      = r_col;
        w_row_nxt      = r_row;
        w_row_base_nxt = r_row_base;
        w_phase_nxt    = r_phase;
        w_byte1_nxt    = r_byte1;
        w_we_nxt       = 1'b0;
        w_addr_nxt     = r_addr;
        w_data_nxt     = r_data;
        w_err_nxt      = r_err;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;

        if (w_start_frame) begin
            w_col_nxt      = '0;
            w_row_nxt      = '0;
            w_row_base_nxt = '0;
            w_phase_nxt    = 1'b0;
            w_busy_nxt     = 1'b1;
        end

        // A frame cut short mid-line or with the wrong line count is a framing error
        if (w_end_frame) begin
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_phase_nxt = 1'b0;
            if ((r_row != ROW_MAX) || (r_state == S_LINE)) w_err_nxt = 1'b1;
        end

        if (w_in_line) begin
            // Byte on the same clk as href falling is still part of the line
            if (w_pclk_rise && (w_href || w_href_fall)) begin
                if (!r_phase) begin
                    w_byte1_nxt = r_data_s2;
                    w_phase_nxt = 1'b1;
                end else begin
                    w_phase_nxt = 1'b0;
                    if ((r_col < COL_MAX) && (r_row < ROW_MAX)) begin
                        w_we_nxt   = 1'b1;
                        w_addr_nxt = r_row_base + AW'(r_col);
                        w_data_nxt = w_pix;
                    end
                    if (r_col < COL_MAX) w_col_nxt = r_col + 1'b1;
                end
            end

            if (w_href_fall) begin
                if ((w_col_nxt != '0) && (r_row < ROW_MAX)) begin
                    w_row_nxt      = r_row + 1'b1;
                    w_row_base_nxt = r_row_base + AW'(CAM_SCREEN_X);
                end
                if (w_phase_nxt) w_err_nxt = 1'b1;
                w_phase_nxt = 1'b0;
                w_col_nxt   = '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= '0;
            r_phase    <= 1'b0;
            r_byte1    <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_col      <= w_col_nxt;
            r_row      <= w_row_nxt;
            r_row_base <= w_row_base_nxt;
            r_phase    <= w_phase_nxt;
            r_byte1    <= w_byte1_nxt;
            r_we       <= w_we_nxt;
            r_addr     <= w_addr_nxt;
            r_data     <= w_data_nxt;
            r_err      <= w_err_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign o_ram.ram_addr = r_addr;
    assign o_ram.ram_data = r_data;
    assign o_ram.ram_we   = r_we;
    assign o_frame_done   = r_done;
    assign o_frame_err    = r_err;
    assign o_busy         = r_busy;

    logic w_unused;
    assign w_unused = ^{w_pclk_level, w_pclk_fall, w_vs_rise, w_vs_fall, r_byte1[4:3]};

endmodule
